// File: rtl/pipe_pkg.sv
// Shared constants, ID/EX record and small decode helpers for the decode stage.
// Record field widths follow the P_* constants, so top-level parameters must match them.
package pipe_pkg;

   localparam int P_XLEN  = 32;
   localparam int P_PC_W  = 13;
   localparam int P_RA_W  = 5;
   localparam int P_ALU_W = 4;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;

   localparam logic [P_ALU_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [P_ALU_W-1:0] ALU_SUB   = 4'd1;
   localparam logic [P_ALU_W-1:0] ALU_AND   = 4'd2;
   localparam logic [P_ALU_W-1:0] ALU_OR    = 4'd3;
   localparam logic [P_ALU_W-1:0] ALU_XOR   = 4'd4;
   localparam logic [P_ALU_W-1:0] ALU_SLL   = 4'd5;
   localparam logic [P_ALU_W-1:0] ALU_SRL   = 4'd6;
   localparam logic [P_ALU_W-1:0] ALU_SRA   = 4'd7;
   localparam logic [P_ALU_W-1:0] ALU_SLT   = 4'd8;
   localparam logic [P_ALU_W-1:0] ALU_SLTU  = 4'd9;
   localparam logic [P_ALU_W-1:0] ALU_PASSB = 4'd10;

   typedef struct packed {
      logic                 valid;
      logic                 reg_write;
      logic                 mem_write;
      logic                 br;
      logic                 jump;
      logic                 op_b_sel;
      logic [P_ALU_W-1:0]   alu_ctrl;
      logic [1:0]           result_src;
      logic [P_XLEN-1:0]    rs1;
      logic [P_XLEN-1:0]    rs2;
      logic [P_XLEN-1:0]    imm;
      logic [P_RA_W-1:0]    rd_addr;
      logic [P_RA_W-1:0]    rs1_addr;
      logic [P_RA_W-1:0]    rs2_addr;
      logic [P_PC_W-1:0]    pc;
      logic [P_PC_W-1:0]    pc4;
   } id_ex_t;

   localparam id_ex_t ID_EX_BUBBLE = '0;

   function automatic logic uses_rs1(input logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
   endfunction

   // funct7 bit 5 selects SUB only for register-register ops; for shifts it always selects SRA.
   function automatic logic [P_ALU_W-1:0] alu_sel(input logic [2:0] f3, input logic f7b5,
                                                  input logic is_r);
      logic [P_ALU_W-1:0] sel;
      case (f3)
         3'b000:  sel = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  sel = ALU_SLL;
         3'b010:  sel = ALU_SLT;
         3'b011:  sel = ALU_SLTU;
         3'b100:  sel = ALU_XOR;
         3'b101:  sel = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  sel = ALU_OR;
         default: sel = ALU_AND;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/ctrl_unit.sv
// Main decoder: opcode/funct fields to pipeline control signals.
module ctrl_unit
   import pipe_pkg::*;
(
   input  logic [6:0]         op_i,
   input  logic [2:0]         funct3_i,
   input  logic               funct7b5_i,
   output logic               reg_write_o,
   output logic               mem_write_o,
   output logic               branch_o,
   output logic               jump_o,
   output logic               alu_src_o,
   output logic [1:0]         result_src_o,
   output logic [P_ALU_W-1:0] alu_ctrl_o
);

   always_comb begin
      reg_write_o  = 1'b0;
      mem_write_o  = 1'b0;
      branch_o     = 1'b0;
      jump_o       = 1'b0;
      alu_src_o    = 1'b0;
      result_src_o = WB_SEL_ALU;
      alu_ctrl_o   = ALU_ADD;
      case (op_i)
         OP_R: begin
            reg_write_o = 1'b1;
            alu_ctrl_o  = alu_sel(funct3_i, funct7b5_i, 1'b1);
         end
         OP_I: begin
            reg_write_o = 1'b1;
            alu_src_o   = 1'b1;
            alu_ctrl_o  = alu_sel(funct3_i, funct7b5_i, 1'b0);
         end
         OP_LOAD: begin
            reg_write_o  = 1'b1;
            alu_src_o    = 1'b1;
            result_src_o = WB_SEL_LOAD;
         end
         OP_STORE: begin
            mem_write_o = 1'b1;
            alu_src_o   = 1'b1;
         end
         OP_BRANCH: begin
            branch_o   = 1'b1;
            alu_ctrl_o = (funct3_i[2:1] == 2'b00) ? ALU_SUB :
                         funct3_i[1]              ? ALU_SLTU : ALU_SLT;
         end
         OP_JAL: begin
            reg_write_o  = 1'b1;
            jump_o       = 1'b1;
            result_src_o = WB_SEL_PC4;
         end
         OP_JALR: begin
            reg_write_o  = 1'b1;
            jump_o       = 1'b1;
            alu_src_o    = 1'b1;
            result_src_o = WB_SEL_PC4;
         end
         OP_LUI: begin
            reg_write_o = 1'b1;
            alu_src_o   = 1'b1;
            alu_ctrl_o  = ALU_PASSB;
         end
         OP_AUIPC: begin
            reg_write_o = 1'b1;
            alu_src_o   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_stage_pipe_regfile.sv
// 2-read/1-write register file with x0 tied to zero and same-cycle write-through to both read ports.
module regfile_wt #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [RA_W-1:0] ra1_i,
   input  logic [RA_W-1:0] ra2_i,
   output logic [XLEN-1:0] rd1_o,
   output logic [XLEN-1:0] rd2_o,
   input  logic            we_i,
   input  logic [RA_W-1:0] wa_i,
   input  logic [XLEN-1:0] wd_i
);

   localparam int NREG = 2 ** RA_W;

   logic [XLEN-1:0] mem_q [NREG];
   logic            wr_en;

   assign wr_en = we_i && (wa_i != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wa_i] <= wd_i;
      end
   end

   assign rd1_o = (ra1_i == '0)                 ? '0   :
                  (wr_en && (wa_i == ra1_i))    ? wd_i : mem_q[ra1_i];
   assign rd2_o = (ra2_i == '0)                 ? '0   :
                  (wr_en && (wa_i == ra2_i))    ? wd_i : mem_q[ra2_i];

endmodule

// File: rtl/immediate_generator.sv
// Extracts and sign-extends the immediate for each instruction format, chosen by opcode.
module immediate_generator
   import pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (instr_i[6:0])
         OP_I, OP_LOAD, OP_JALR:
            imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         OP_STORE:
            imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         OP_BRANCH:
            imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
         OP_JAL:
            imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
         OP_LUI, OP_AUIPC:
            imm32 = {instr_i[31:12], 12'b0};
         default:
            imm32 = '0;
      endcase
   end

   assign imm_o = XLEN'(signed'(imm32));

endmodule

// File: rtl/decode_stage_pipe.sv
// ID stage: decode, register read with WB bypass, load-use detection and the ID/EX register.
// Flush beats downstream stall, which beats the load-use bubble.
module decode_stage_pipe
   import pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int PC_W  = 13,
   parameter int RA_W  = 5,
   parameter int ALU_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  InstrD,
   input  logic             valid_D,
   input  logic [PC_W-1:0]  PCD,
   input  logic [PC_W-1:0]  PCPlus4D,
   input  logic             RegWriteW,
   input  logic [RA_W-1:0]  rd_addr_W,
   input  logic [XLEN-1:0]  ResultW,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic             stall_D_o,
   output logic             valid_E,
   output logic             RegWriteE,
   output logic             MemWriteE,
   output logic             BrE,
   output logic             JumpE,
   output logic             op_b_sel_E,
   output logic [ALU_W-1:0] ALUControlE,
   output logic [1:0]       ResultSrcE,
   output logic [XLEN-1:0]  rs1_E,
   output logic [XLEN-1:0]  rs2_E,
   output logic [XLEN-1:0]  immOut_E,
   output logic [RA_W-1:0]  rd_addr_E,
   output logic [RA_W-1:0]  rs1_addr_E,
   output logic [RA_W-1:0]  rs2_addr_E,
   output logic [PC_W-1:0]  PCE,
   output logic [PC_W-1:0]  PCPlus4E,
   output logic [RA_W-1:0]  rs1_addr_D_out,
   output logic [RA_W-1:0]  rs2_addr_D_out
);

   id_ex_t ex_q, ex_d, dec;

   logic [6:0]         opcode;
   logic [XLEN-1:0]    rf_rd1, rf_rd2, imm_w;
   logic               c_reg_write, c_mem_write, c_branch, c_jump, c_alu_src;
   logic [1:0]         c_result_src;
   logic [P_ALU_W-1:0] c_alu_ctrl;
   logic               lu;

   assign opcode         = InstrD[6:0];
   assign rs1_addr_D_out = InstrD[15 +: RA_W];
   assign rs2_addr_D_out = InstrD[20 +: RA_W];

   regfile_wt #(
      .XLEN (XLEN),
      .RA_W (RA_W)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .ra1_i (rs1_addr_D_out),
      .ra2_i (rs2_addr_D_out),
      .rd1_o (rf_rd1),
      .rd2_o (rf_rd2),
      .we_i  (RegWriteW),
      .wa_i  (rd_addr_W),
      .wd_i  (ResultW)
   );

   ctrl_unit u_ctrl (
      .op_i         (opcode),
      .funct3_i     (InstrD[14:12]),
      .funct7b5_i   (InstrD[30]),
      .reg_write_o  (c_reg_write),
      .mem_write_o  (c_mem_write),
      .branch_o     (c_branch),
      .jump_o       (c_jump),
      .alu_src_o    (c_alu_src),
      .result_src_o (c_result_src),
      .alu_ctrl_o   (c_alu_ctrl)
   );

   immediate_generator #(
      .XLEN (XLEN)
   ) u_immgen (
      .instr_i (InstrD[31:0]),
      .imm_o   (imm_w)
   );

   // An empty ID slot still carries its decoded fields, but can never write or redirect.
   always_comb begin
      dec            = ID_EX_BUBBLE;
      dec.valid      = valid_D;
      dec.reg_write  = valid_D & c_reg_write;
      dec.mem_write  = valid_D & c_mem_write;
      dec.br         = valid_D & c_branch;
      dec.jump       = valid_D & c_jump;
      dec.op_b_sel   = c_alu_src;
      dec.alu_ctrl   = c_alu_ctrl;
      dec.result_src = c_result_src;
      dec.rs1        = rf_rd1;
      dec.rs2        = rf_rd2;
      dec.imm        = imm_w;
      dec.rd_addr    = InstrD[7 +: RA_W];
      dec.rs1_addr   = rs1_addr_D_out;
      dec.rs2_addr   = rs2_addr_D_out;
      dec.pc         = PCD;
      dec.pc4        = PCPlus4D;
   end

   assign lu = valid_D & ex_q.valid & ex_q.reg_write &
               (ex_q.result_src == WB_SEL_LOAD) & (ex_q.rd_addr != '0) &
               ((uses_rs1(opcode) & (rs1_addr_D_out == ex_q.rd_addr)) |
                (uses_rs2(opcode) & (rs2_addr_D_out == ex_q.rd_addr)));

   assign stall_D_o = ~flush_i & (stall_i | lu);

   always_comb begin
      ex_d = ex_q;
      if (flush_i) begin
         ex_d = ID_EX_BUBBLE;
      end else if (stall_i) begin
         ex_d = ex_q;
      end else if (lu) begin
         ex_d = ID_EX_BUBBLE;
      end else begin
         ex_d = dec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ex_q <= ID_EX_BUBBLE;
      else     ex_q <= ex_d;
   end

   assign valid_E     = ex_q.valid;
   assign RegWriteE   = ex_q.reg_write;
   assign MemWriteE   = ex_q.mem_write;
   assign BrE         = ex_q.br;
   assign JumpE       = ex_q.jump;
   assign op_b_sel_E  = ex_q.op_b_sel;
   assign ALUControlE = ex_q.alu_ctrl;
   assign ResultSrcE  = ex_q.result_src;
   assign rs1_E       = ex_q.rs1;
   assign rs2_E       = ex_q.rs2;
   assign immOut_E    = ex_q.imm;
   assign rd_addr_E   = ex_q.rd_addr;
   assign rs1_addr_E  = ex_q.rs1_addr;
   assign rs2_addr_E  = ex_q.rs2_addr;
   assign PCE         = ex_q.pc;
   assign PCPlus4E    = ex_q.pc4;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomized bench for decode_stage_pipe against an opcode-table reference model.
module tb_decode_stage_pipe;
   import pipe_pkg::*;

   localparam int XLEN = 32, PC_W = 13, RA_W = 5, ALU_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [XLEN-1:0]  InstrD;
   logic             valid_D;
   logic [PC_W-1:0]  PCD, PCPlus4D;
   logic             RegWriteW;
   logic [RA_W-1:0]  rd_addr_W;
   logic [XLEN-1:0]  ResultW;
   logic             stall_i, flush_i;
   logic             stall_D_o, valid_E, RegWriteE, MemWriteE, BrE, JumpE, op_b_sel_E;
   logic [ALU_W-1:0] ALUControlE;
   logic [1:0]       ResultSrcE;
   logic [XLEN-1:0]  rs1_E, rs2_E, immOut_E;
   logic [RA_W-1:0]  rd_addr_E, rs1_addr_E, rs2_addr_E, rs1_addr_D_out, rs2_addr_D_out;
   logic [PC_W-1:0]  PCE, PCPlus4E;

   always #5 clk = ~clk;

   decode_stage_pipe #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W), .ALU_W(ALU_W)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .valid_D(valid_D), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .rd_addr_W(rd_addr_W), .ResultW(ResultW),
      .stall_i(stall_i), .flush_i(flush_i), .stall_D_o(stall_D_o), .valid_E(valid_E),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BrE(BrE), .JumpE(JumpE),
      .op_b_sel_E(op_b_sel_E), .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE),
      .rs1_E(rs1_E), .rs2_E(rs2_E), .immOut_E(immOut_E), .rd_addr_E(rd_addr_E),
      .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .rs1_addr_D_out(rs1_addr_D_out), .rs2_addr_D_out(rs2_addr_D_out)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state: expected EX slot and architectural register contents.
   typedef struct packed {
      logic v, rw, mw, br, jp, obs;
      logic [1:0] rsrc;
      logic [31:0] a, b, imm;
      logic [4:0] rd, r1, r2;
      logic [12:0] pc, pc4;
   } exm_t;

   exm_t        m_e;
   logic [31:0] m_rf [32];
   logic        stall_seen;
   logic [6:0]  ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

   function automatic logic m_uses1(input logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic logic m_uses2(input logic [6:0] op);
      return op == OP_R || op == OP_STORE || op == OP_BRANCH;
   endfunction

   // {RegWrite, MemWrite, Branch, Jump, operand-B-is-imm, WB select}
   function automatic logic [6:0] m_ctl(input logic [6:0] op);
      case (op)
         OP_R:      return {5'b10000, WB_SEL_ALU};
         OP_I:      return {5'b10001, WB_SEL_ALU};
         OP_LOAD:   return {5'b10001, WB_SEL_LOAD};
         OP_STORE:  return {5'b01001, WB_SEL_ALU};
         OP_BRANCH: return {5'b00100, WB_SEL_ALU};
         OP_JAL:    return {5'b10010, WB_SEL_PC4};
         OP_JALR:   return {5'b10011, WB_SEL_PC4};
         OP_LUI:    return {5'b10001, WB_SEL_ALU};
         OP_AUIPC:  return {5'b10001, WB_SEL_ALU};
         default:   return 7'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_imm(input logic [31:0] i);
      int v;
      case (i[6:0])
         OP_I, OP_LOAD, OP_JALR: v = int'($signed(i[31:20]));
         OP_STORE:               v = int'($signed({i[31:25], i[11:7]}));
         OP_BRANCH:              v = int'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
         OP_JAL:                 v = int'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
         OP_LUI, OP_AUIPC:       v = int'({12'b0, i[31:12]}) << 12;
         default:                v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if (we && wa == a) return wd;
      return m_rf[a];
   endfunction

   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, OP_R};
   endfunction

   function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
   endfunction

   // One ID cycle: drive at negedge, check stall_D_o, advance the model, check EX after the edge.
   task automatic step(input logic [31:0] ins, input logic vd, input logic [12:0] pc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic st, input logic fl);
      logic lu, exp_st;
      logic [6:0] c;
      exm_t nx;
      InstrD = ins; valid_D = vd; PCD = pc; PCPlus4D = pc + 13'd4;
      RegWriteW = we; rd_addr_W = wa; ResultW = wd; stall_i = st; flush_i = fl;
      #1;
      lu = vd && m_e.v && m_e.rw && m_e.rsrc == WB_SEL_LOAD && m_e.rd != 5'd0 &&
           ((m_uses1(ins[6:0]) && ins[19:15] == m_e.rd) ||
            (m_uses2(ins[6:0]) && ins[24:20] == m_e.rd));
      exp_st = !fl && (st || lu);
      stall_seen = stall_D_o;
      check_val("stall_D", stall_D_o, exp_st);
      check_val("rs_addr_D", {rs1_addr_D_out, rs2_addr_D_out}, {ins[19:15], ins[24:20]});
      c = m_ctl(ins[6:0]);
      if (fl || (!st && lu)) begin
         nx = '0;
      end else if (st) begin
         nx = m_e;
      end else begin
         nx = '{v: vd, rw: c[6] & vd, mw: c[5] & vd, br: c[4] & vd, jp: c[3] & vd,
                obs: c[2], rsrc: c[1:0],
                a: m_read(ins[19:15], we, wa, wd), b: m_read(ins[24:20], we, wa, wd),
                imm: m_imm(ins), rd: ins[11:7], r1: ins[19:15], r2: ins[24:20],
                pc: pc, pc4: pc + 13'd4};
      end
      if (we && wa != 5'd0) m_rf[wa] = wd;
      m_e = nx;
      @(negedge clk);
      check_val("ctrl_E", {valid_E, RegWriteE, MemWriteE, BrE, JumpE, op_b_sel_E, ResultSrcE},
                {m_e.v, m_e.rw, m_e.mw, m_e.br, m_e.jp, m_e.obs, m_e.rsrc});
      check_val("rs1_E", rs1_E, m_e.a);
      check_val("rs2_E", rs2_E, m_e.b);
      check_val("imm_E", immOut_E, m_e.imm);
      check_val("addr_E", {rd_addr_E, rs1_addr_E, rs2_addr_E}, {m_e.rd, m_e.r1, m_e.r2});
      check_val("pc_E", {PCE, PCPlus4E}, {m_e.pc, m_e.pc4});
   endtask

   task automatic model_reset();
      m_e = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
   endtask

   initial begin
      logic [31:0] cur_ins;
      logic        cur_vd;
      logic [12:0] cur_pc;
      int          k;

      rst = 1'b1; InstrD = '0; valid_D = 1'b0; PCD = '0; PCPlus4D = '0;
      RegWriteW = 1'b0; rd_addr_W = '0; ResultW = '0; stall_i = 1'b0; flush_i = 1'b0;
      model_reset();
      stall_seen = 1'b0;
      @(negedge clk); @(negedge clk);
      check_val("reset_ctrl", {valid_E, RegWriteE, MemWriteE, BrE, JumpE, ResultSrcE}, 0);
      check_val("reset_data", {rs1_E, rs2_E}, 0);
      rst = 1'b0;

      // Basic pass-through.
      step(enc_i(OP_I, 5'd3, 5'd0, 12'd5), 1'b1, 13'h010, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      check_val("addi_valid", {valid_E, RegWriteE}, 2'b11);
      check_val("addi_imm", immOut_E, 32'd5);
      check_val("addi_rd", rd_addr_E, 5'd3);
      check_val("addi_pc", {PCE, PCPlus4E}, {13'h010, 13'h014});
      check_val("addi_alu", ALUControlE, ALU_ADD);

      // WB write-through, and x0 immune to writes.
      step(enc_r(5'd6, 5'd5, 5'd5), 1'b1, 13'h014, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
      check_val("wt_rs", {rs1_E, rs2_E}, {32'hDEADBEEF, 32'hDEADBEEF});
      step(enc_r(5'd6, 5'd0, 5'd0), 1'b1, 13'h018, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0);
      check_val("wt_x0", {rs1_E, rs2_E}, 64'd0);

      // Load-use bubble, then the consumer enters; LUI never waits.
      step(enc_i(OP_LOAD, 5'd6, 5'd1, 12'd0), 1'b1, 13'h020, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(enc_r(5'd7, 5'd6, 5'd1), 1'b1, 13'h024, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      check_val("lu_stall", stall_seen, 1'b1);
      check_val("lu_bubble", valid_E, 1'b0);
      step(enc_r(5'd7, 5'd6, 5'd1), 1'b1, 13'h024, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      check_val("lu_release", {stall_seen, valid_E, rd_addr_E}, {1'b0, 1'b1, 5'd7});
      step(enc_i(OP_LOAD, 5'd6, 5'd1, 12'd0), 1'b1, 13'h028, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step({20'd1, 5'd6, OP_LUI}, 1'b1, 13'h02C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      check_val("lui_nostall", {stall_seen, valid_E}, 2'b01);

      // Flush beats both stall and hazard.
      step(enc_i(OP_LOAD, 5'd6, 5'd1, 12'd0), 1'b1, 13'h030, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(enc_r(5'd7, 5'd6, 5'd1), 1'b1, 13'h034, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
      check_val("flush_stallD", stall_seen, 1'b0);
      check_val("flush_bubble", {valid_E, RegWriteE, MemWriteE}, 3'b000);

      // Downstream hold with a store in EX.
      step(enc_s(5'd1, 5'd2, 12'd4), 1'b1, 13'h040, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(enc_i(OP_I, 5'd9, 5'd0, 12'd9), 1'b1, 13'h044, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
         check_val("hold_stallD", stall_seen, 1'b1);
         check_val("hold_sw", {valid_E, MemWriteE, immOut_E}, {1'b1, 1'b1, 32'd4});
      end
      step(enc_i(OP_I, 5'd9, 5'd0, 12'd9), 1'b1, 13'h044, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      check_val("hold_release", {valid_E, MemWriteE, rd_addr_E}, {1'b1, 1'b0, 5'd9});

      // Asynchronous reset mid-program.
      step(enc_i(OP_I, 5'd1, 5'd0, 12'd7), 1'b1, 13'h048, 1'b1, 5'd1, 32'h77, 1'b0, 1'b0);
      check_val("pre_rst", {valid_E, RegWriteE}, 2'b11);
      #2;
      rst = 1'b1;
      #1;
      check_val("rst_ctrl", {valid_E, RegWriteE, MemWriteE, BrE, JumpE, op_b_sel_E,
                             ALUControlE, ResultSrcE}, 0);
      check_val("rst_data", {rs1_E, immOut_E}, 0);
      check_val("rst_addr_pc", {rd_addr_E, PCE, PCPlus4E}, 0);
      check_val("rst_stallD", stall_D_o, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(enc_r(5'd6, 5'd1, 5'd1), 1'b1, 13'h000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      check_val("rst_x1", rs1_E, 32'd0);

      // Random traffic; ID holds its instruction whenever the stage stalls it.
      cur_ins = '0; cur_vd = 1'b0; cur_pc = 13'h100;
      for (int n = 0; n < 400; n++) begin
         if (!stall_seen || n == 0) begin
            k = int'($urandom_range(0, 11));
            cur_ins = $urandom;
            cur_ins[6:0]   = (k > 8) ? OP_LOAD : ops[k];
            cur_ins[11:7]  = 5'($urandom_range(0, 7));
            cur_ins[19:15] = 5'($urandom_range(0, 7));
            cur_ins[24:20] = 5'($urandom_range(0, 7));
            cur_vd = ($urandom_range(0, 9) != 0);
            cur_pc = cur_pc + 13'd4;
         end
         step(cur_ins, cur_vd, cur_pc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
